lzc_normalizer: RTL
===================

Name: lzc_normalizer

Overview:
- Pipelined left-normalizer that consumes the leading-zero count of an operand and shifts the operand so its MSB is 1.
- Sits directly downstream of the leading-zero counter in the FP/integer normalization path. It instantiates the counter combinationally in stage 1 and registers its count.
- Two-stage valid/ready pipeline, throughput one operand per cycle.

Parameters:
- WIDTH, 32, operand width in bits (>=2)
- EXPW, 10, exponent width in bits; used only with LZC_NORM_EXP_EN

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- InValid  input  1  upstream operand valid
- InReady  output  1  block can accept operand this cycle
- Num  input  WIDTH  operand to normalize
- OutValid  output  1  normalized result valid
- OutReady  input  1  downstream accepts result this cycle
- NormNum  output  WIDTH  Num shifted left by ShiftAmt
- ShiftAmt  output  $clog2(WIDTH+1)  leading-zero count of Num
- Zero  output  1  Num was all zeros

Behaviour:
- Reset (async, active-high, immediate): V1, V2, NormNum, ShiftAmt and Zero clear to 0. Any in-flight operands are discarded; there is no partial output after reset.
- Stage 1 register holds Num and its leading-zero count Cnt1, plus valid V1.
- Stage 2 register holds NormNum, ShiftAmt and Zero, plus valid V2.
- Output drives: OutValid = V2. NormNum, ShiftAmt and Zero come straight from stage 2 registers, with no combinational path from inputs.
- Handshake:
  - Adv2 = V1 & (~V2 | OutReady)
  - InReady = ~V1 | ~V2 | OutReady (combinational, from OutReady and state only; never depends on InValid)
  - Accept = InValid & InReady
- Stage 1 update: on Accept, load Num and its count and set V1=1. Otherwise, if Adv2, clear V1.
- Stage 2 update: on Adv2, load NormNum = Num1 << Cnt1 (truncated to WIDTH), ShiftAmt = Cnt1, Zero = (Cnt1 == WIDTH), and set V2=1. Otherwise, if OutReady, clear V2.
- Latency: 2 cycles from Accept to OutValid. Full pipeline with OutReady=1 sustains 1/cycle with no bubbles.
- Stall: while OutValid & ~OutReady, the outputs must hold bit-stable. Stage 1 may still fill; once both stages are full, InReady=0.
- All-zero operand: ShiftAmt = WIDTH, NormNum = 0, Zero = 1.
- MSB already set: ShiftAmt = 0, NormNum = Num.
- InValid while InReady=0: operand is not taken. Upstream holds it (standard valid/ready contract).
- Simultaneous events: Accept, Adv2 and drain may all occur in one cycle without loss or duplication.

Optional Feature:
- Macro: LZC_NORM_EXP_EN
- Defined:
  - Adds ports ExpIn (input, EXPW, signed), ExpOut (output, EXPW, signed) and Uflow (output, 1).
  - ExpIn is captured with Num on Accept and travels with it through stage 1.
  - Stage 2 computes ExpIn - ShiftAmt in EXPW+1 bits.
  - If the result is below -2^(EXPW-1): ExpOut saturates to -2^(EXPW-1) and Uflow=1. Otherwise ExpOut is the difference and Uflow=0.
  - Zero=1 forces Uflow=0 and ExpOut=ExpIn.
  - Both new outputs reset to 0.
- Undefined: those ports and registers are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, Num=0x10 accepted at cycle 0, OutReady=1 -> cycle 2: OutValid=1, NormNum=0x80, ShiftAmt=3, Zero=0.
- WIDTH=8, Num=0x00 -> NormNum=0x00, ShiftAmt=8, Zero=1. Then Num=0xC3 -> ShiftAmt=0, NormNum=0xC3.
- Back-to-back Num=0x01,0x02,0x04,0x08 with InValid=1, OutReady=1 -> InReady stays 1; outputs on 4 consecutive cycles with ShiftAmt=7,6,5,4, all NormNum=0x80.
- OutReady=0 for 4 cycles while streaming 0x01,0x20,0x40:
  - InReady falls after 2 accepts.
  - NormNum stays 0x80, ShiftAmt stays 7 for the whole stall.
  - After OutReady=1, results follow in order: 0x80/7, then 0x80/2, then 0x80/1.
- Assert reset with both stages valid -> OutValid=0 and InReady=1 immediately. No stale result appears after release.
- LZC_NORM_EXP_EN, WIDTH=8, EXPW=8:
  - ExpIn=-126, Num=0x01 -> ExpOut=-128 (saturated), Uflow=1.
  - ExpIn=5, Num=0x08 -> ExpOut=1, Uflow=0.

Source files
------------

// File: rtl/lzc_normalizer.sv
// lzc_normalizer
// ---------------------------------------------------------------------------
// Two-stage valid/ready left-normalizer. Stage 1 registers the operand and
// its leading-zero count (computed combinationally from Num). Stage 2
// registers the operand shifted left by that count, so the MSB of the result
// is 1 unless the operand was all zeros.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   InValid/InReady upstream handshake; Num is the operand
//   OutValid/OutReady downstream handshake
//   NormNum         Num << ShiftAmt (truncated to WIDTH)
//   ShiftAmt        leading-zero count of Num (WIDTH when Num == 0)
//   Zero            Num was all zeros
//
// Optional feature, enabled by defining LZC_NORM_EXP_EN:
//   ExpIn  (signed EXPW) exponent travelling with Num
//   ExpOut (signed EXPW) ExpIn - ShiftAmt, saturated at -2^(EXPW-1)
//   Uflow             saturation occurred
// With LZC_NORM_EXP_EN undefined these ports and their registers are absent.
// ---------------------------------------------------------------------------
module lzc_normalizer #(
  parameter int WIDTH = 32,
  parameter int EXPW  = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         InValid,
  output logic                         InReady,
  input  logic [WIDTH-1:0]             Num,
  output logic                         OutValid,
  input  logic                         OutReady,
  output logic [WIDTH-1:0]             NormNum,
  output logic [$clog2(WIDTH+1)-1:0]   ShiftAmt,
  output logic                         Zero
`ifdef LZC_NORM_EXP_EN
  ,
  input  logic signed [EXPW-1:0]       ExpIn,
  output logic signed [EXPW-1:0]       ExpOut,
  output logic                         Uflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int EW = EXPW + 1;

  // Reject configurations the datapath cannot represent.
  if (WIDTH < 2 || EXPW < 2) begin : gBadParam
    $error("lzc_normalizer: WIDTH and EXPW must both be >= 2");
  end

  // Stage 1 state
  logic             valid1_q, valid1_d;
  logic [WIDTH-1:0] num1_q, num1_d;
  logic [CW-1:0]    cnt1_q, cnt1_d;

  // Stage 2 state
  logic             valid2_q, valid2_d;
  logic [WIDTH-1:0] normNum_q, normNum_d;
  logic [CW-1:0]    shiftAmt_q, shiftAmt_d;
  logic             zero_q, zero_d;

`ifdef LZC_NORM_EXP_EN
  logic signed [EXPW-1:0] exp1_q, exp1_d;
  logic signed [EXPW-1:0] expOut_q, expOut_d;
  logic                   uflow_q, uflow_d;
  logic signed [EW-1:0]   expDiff;
  // -2^(EXPW-1) sign-extended to EW bits
  localparam logic signed [EW-1:0] ExpMin = {2'b11, {(EXPW-1){1'b0}}};
`endif

  logic          adv2;
  logic          accept;
  logic [CW-1:0] lzCount;
  logic          found;

  // Leading-zero counter on the incoming operand. Scans from the MSB and
  // latches the position of the first 1; an all-zero operand yields WIDTH.
  always_comb begin
    lzCount = CW'(WIDTH);
    found   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && Num[i]) begin
        lzCount = CW'(WIDTH - 1 - i);
        found   = 1'b1;
      end
    end
  end

  // Handshake. InReady is derived from state and OutReady only, so it never
  // forms a loop through the upstream InValid.
  always_comb begin
    adv2    = valid1_q & (~valid2_q | OutReady);
    InReady = ~valid1_q | ~valid2_q | OutReady;
    accept  = InValid & InReady;
  end

`ifdef LZC_NORM_EXP_EN
  // Exponent adjust in one extra bit so the underflow is visible as a
  // value below the representable minimum.
  always_comb begin
    expDiff = {exp1_q[EXPW-1], exp1_q} - EW'(cnt1_q);
  end
`endif

  // Next-state for both stages. A stage loads only when its enable fires,
  // which keeps the outputs bit-stable during a downstream stall.
  always_comb begin
    valid1_d   = valid1_q;
    num1_d     = num1_q;
    cnt1_d     = cnt1_q;
    valid2_d   = valid2_q;
    normNum_d  = normNum_q;
    shiftAmt_d = shiftAmt_q;
    zero_d     = zero_q;
`ifdef LZC_NORM_EXP_EN
    exp1_d     = exp1_q;
    expOut_d   = expOut_q;
    uflow_d    = uflow_q;
`endif

    if (accept) begin
      valid1_d = 1'b1;
      num1_d   = Num;
      cnt1_d   = lzCount;
`ifdef LZC_NORM_EXP_EN
      exp1_d   = ExpIn;
`endif
    end else if (adv2) begin
      valid1_d = 1'b0;
    end

    if (adv2) begin
      valid2_d   = 1'b1;
      normNum_d  = num1_q << cnt1_q;
      shiftAmt_d = cnt1_q;
      zero_d     = (cnt1_q == CW'(WIDTH));
`ifdef LZC_NORM_EXP_EN
      // A zero operand has no meaningful normalization, so its exponent
      // passes through untouched.
      if (cnt1_q == CW'(WIDTH)) begin
        expOut_d = exp1_q;
        uflow_d  = 1'b0;
      end else if (expDiff < ExpMin) begin
        expOut_d = ExpMin[EXPW-1:0];
        uflow_d  = 1'b1;
      end else begin
        expOut_d = expDiff[EXPW-1:0];
        uflow_d  = 1'b0;
      end
`endif
    end else if (OutReady) begin
      valid2_d = 1'b0;
    end
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid1_q   <= 1'b0;
      num1_q     <= '0;
      cnt1_q     <= '0;
      valid2_q   <= 1'b0;
      normNum_q  <= '0;
      shiftAmt_q <= '0;
      zero_q     <= 1'b0;
`ifdef LZC_NORM_EXP_EN
      exp1_q     <= '0;
      expOut_q   <= '0;
      uflow_q    <= 1'b0;
`endif
    end else begin
      valid1_q   <= valid1_d;
      num1_q     <= num1_d;
      cnt1_q     <= cnt1_d;
      valid2_q   <= valid2_d;
      normNum_q  <= normNum_d;
      shiftAmt_q <= shiftAmt_d;
      zero_q     <= zero_d;
`ifdef LZC_NORM_EXP_EN
      exp1_q     <= exp1_d;
      expOut_q   <= expOut_d;
      uflow_q    <= uflow_d;
`endif
    end
  end

  // Outputs come straight from stage 2 registers.
  assign OutValid = valid2_q;
  assign NormNum  = normNum_q;
  assign ShiftAmt = shiftAmt_q;
  assign Zero     = zero_q;
`ifdef LZC_NORM_EXP_EN
  assign ExpOut   = expOut_q;
  assign Uflow    = uflow_q;
`endif

endmodule
